// File: rtl/cdec_dp_gen_pkg.sv
// cdec_dp_pkg: XBUS source/destination codes, mmrw encodings, memory FSM states and debug readout addresses
package cdec_dp_pkg;
  localparam logic [3:0] XS_PC = 4'd0, XS_R = 4'd4, XS_RDR = 4'd5, XS_FLG = 4'd6, XS_ONES = 4'd7, XS_IPORT = 4'd8;
  localparam logic [3:0] XD_PC = 4'd0, XD_MAR = 4'd4, XD_WDR = 4'd5, XD_T = 4'd6, XD_I = 4'd7, XD_IO = 4'd8;
  localparam logic [1:0] MM_IDLE = 2'b00, MM_RD = 2'b10, MM_WR = 2'b01;
  localparam logic [7:0] DA_PC = 8'h00, DA_I = 8'h01, DA_T = 8'h02, DA_R = 8'h03, DA_MAR = 8'h04;
  localparam logic [7:0] DA_MRD = 8'h05, DA_RDR = 8'h06, DA_WDR = 8'h07, DA_ST = 8'h0B, DA_BUS = 8'h0C;
  localparam logic [7:0] DA_FLG = 8'h0D, DA_X = 8'h0E, DA_IPORT = 8'h0F;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RD = 2'd1, ST_WR = 2'd2} state_t;
  function automatic logic [3:0] gpr_code(input int g);
    return 4'(g < 3 ? g + 1 : g + 6);
  endfunction
  function automatic logic gpr_dbg(input int g, input logic [7:0] a);
    return (g < 3 && a == 8'(8 + g)) || a == 8'(16 + g);
  endfunction
endpackage

// File: rtl/cdec_dp_gen_if.sv
// cdec_dp_gen_if: req/ack memory port (master = data path: req/we/adrs/wdata/err out, rdata/ack in)
interface cdec_dp_gen_if #(parameter int DW = 8, parameter int AW = 8);
  logic mem_req, mem_we, mem_ack, mem_err;
  logic [AW-1:0] mem_adrs;
  logic [DW-1:0] mem_wdata, mem_rdata;
  modport master(output mem_req, mem_we, mem_adrs, mem_wdata, mem_err, input mem_rdata, mem_ack);
  modport slave(input mem_req, mem_we, mem_adrs, mem_wdata, mem_err, output mem_rdata, mem_ack);
endinterface

// File: rtl/cdec_mem_if.sv
// cdec_mem_if: memory FSM with timeout (in: clock, reset, i_mmrw, i_mar, i_wdr; out: o_state, o_rdr, mem master port)
module cdec_mem_if
  import cdec_dp_pkg::*;
#(
  parameter int DW = 8,
  parameter int AW = 8,
  parameter int TMO = 255
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [1:0]    i_mmrw,
  input  logic [AW-1:0] i_mar,
  input  logic [DW-1:0] i_wdr,
  output state_t        o_state,
  output logic [DW-1:0] o_rdr,
  cdec_dp_gen_if.master mem
);
  localparam int CW = TMO > 1 ? $clog2(TMO) : 1;
  state_t r_state;
  logic r_req, r_we, r_err;
  logic [AW-1:0] r_adrs;
  logic [DW-1:0] r_wdata, r_rdr;
  logic [CW-1:0] r_cnt;
  logic w_tmo;
  assign w_tmo = TMO > 0 && r_cnt == CW'(TMO - 1);
  assign o_state = r_state;
  assign o_rdr = r_rdr;
  assign mem.mem_req = r_req;
  assign mem.mem_we = r_we;
  assign mem.mem_adrs = r_adrs;
  assign mem.mem_wdata = r_wdata;
  assign mem.mem_err = r_err;
  always_ff @(posedge clock)
    if (reset) begin
      r_state <= ST_IDLE;
      {r_req, r_we, r_err} <= '0;
      r_adrs <= '0;
      r_wdata <= '0;
      r_rdr <= '0;
      r_cnt <= '0;
    end else if (r_state == ST_IDLE) begin
      if (i_mmrw == MM_RD || i_mmrw == MM_WR) begin
        r_state <= i_mmrw == MM_RD ? ST_RD : ST_WR;
        r_req <= 1'b1;
        r_we <= i_mmrw == MM_WR;
        r_adrs <= i_mar;
        r_wdata <= i_wdr;
        r_cnt <= '0;
      end
    end else if (mem.mem_ack || w_tmo) begin
      // ack wins over a coincident timeout; the error flag is sticky until reset
      r_state <= ST_IDLE;
      r_req <= 1'b0;
      r_we <= 1'b0;
      if (mem.mem_ack && r_state == ST_RD) r_rdr <= mem.mem_rdata;
      if (!mem.mem_ack) r_err <= 1'b1;
    end else r_cnt <= r_cnt + 1'b1;
endmodule

// File: rtl/cdec_dp_gen.sv
// cdec_dp_gen: CDEC data path (in: clock, reset, ctrl, alu_result/flag, io_in, resad; out: I, SZCy, busy, alu_*, io_out, resdt; mem master port)
module cdec_dp_gen
  import cdec_dp_pkg::*;
#(
  parameter int DW = 8,
  parameter int AW = 8,
  parameter int NGPR = 3,
  parameter int TMO = 255
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [16:0]   ctrl,
  output logic [DW-1:0] I,
  output logic [2:0]    SZCy,
  output logic          busy,
  output logic [DW-1:0] alu_x,
  output logic [DW-1:0] alu_y,
  output logic          alu_cy,
  output logic [4:0]    alu_op,
  input  logic [DW-1:0] alu_result,
  input  logic [2:0]    alu_flag,
  input  logic [DW-1:0] io_in,
  output logic [DW-1:0] io_out,
  input  logic [7:0]    resad,
  output logic [DW-1:0] resdt,
  cdec_dp_gen_if.master mem
);
  logic [1:0] w_mmrw;
  logic w_fwr, w_rwr;
  logic [3:0] w_xdst, w_xsrc;
  logic [DW-1:0] r_pc, r_i, r_t, r_r, r_mar, r_wdr, r_flg, r_ip0, r_ip1, r_io, r_resdt;
  logic [DW-1:0] r_gpr [NGPR];
  logic [DW-1:0] w_rdr, w_x, w_dbg;
  state_t w_state;
  assign {w_mmrw, w_fwr, w_rwr, w_xdst, alu_op, w_xsrc} = ctrl;
  assign I = r_i;
  assign SZCy = r_flg[3:1];
  assign busy = w_state != ST_IDLE;
  assign alu_x = w_x;
  assign alu_y = r_t;
  assign alu_cy = r_flg[1];
  assign io_out = r_io;
  assign resdt = r_resdt;
  cdec_mem_if #(.DW(DW), .AW(AW), .TMO(TMO)) u_mem (
    .clock(clock),
    .reset(reset),
    .i_mmrw(w_mmrw),
    .i_mar(r_mar[AW-1:0]),
    .i_wdr(r_wdr),
    .o_state(w_state),
    .o_rdr(w_rdr),
    .mem(mem)
  );
  always_comb begin
    case (w_xsrc)
      XS_PC: w_x = r_pc;
      XS_R: w_x = r_r;
      XS_RDR: w_x = w_rdr;
      XS_FLG: w_x = r_flg;
      XS_IPORT: w_x = r_ip1;
      default: w_x = '1;
    endcase
    for (int g = 0; g < NGPR; g++) if (w_xsrc == gpr_code(g)) w_x = r_gpr[g];
  end
  always_comb begin
    case (resad)
      DA_PC: w_dbg = r_pc;
      DA_I: w_dbg = r_i;
      DA_T: w_dbg = r_t;
      DA_R: w_dbg = r_r;
      DA_MAR: w_dbg = r_mar;
      DA_MRD: w_dbg = mem.mem_rdata;
      DA_RDR: w_dbg = w_rdr;
      DA_WDR: w_dbg = r_wdr;
      DA_ST: w_dbg = DW'(w_state);
      DA_BUS: w_dbg = DW'({mem.mem_err, busy, mem.mem_ack, mem.mem_req});
      DA_FLG: w_dbg = r_flg;
      DA_X: w_dbg = w_x;
      DA_IPORT: w_dbg = r_ip1;
      default: w_dbg = '1;
    endcase
    for (int g = 0; g < NGPR; g++) if (gpr_dbg(g, resad)) w_dbg = r_gpr[g];
  end
  always_ff @(posedge clock)
    if (reset) begin
      {r_pc, r_i, r_t, r_r, r_mar, r_wdr, r_flg, r_ip0, r_ip1, r_io, r_resdt} <= '0;
      for (int g = 0; g < NGPR; g++) r_gpr[g] <= '0;
    end else begin
      case (w_xdst)
        XD_PC: r_pc <= w_x;
        XD_MAR: r_mar <= w_x;
        XD_WDR: r_wdr <= w_x;
        XD_T: r_t <= w_x;
        XD_I: r_i <= w_x;
        XD_IO: r_io <= w_x;
        default: ;
      endcase
      for (int g = 0; g < NGPR; g++) if (w_xdst == gpr_code(g)) r_gpr[g] <= w_x;
      if (w_rwr) r_r <= alu_result;
      if (w_fwr) r_flg <= DW'({alu_flag, 1'b0});
      {r_ip1, r_ip0} <= {r_ip0, io_in};
      r_resdt <= w_dbg;
    end
endmodule

// File: tb/tb_cdec_dp_gen.sv
// tb_cdec_dp_gen: scoreboard bench for cdec_dp_gen (debug readouts and memory transactions)
module tb_cdec_dp_gen;
  import cdec_dp_pkg::*;
  typedef struct {logic we; logic [7:0] adrs; logic [7:0] wdata;} txn_t;
  logic clock = 1'b0, reset = 1'b1;
  logic [16:0] ctrl;
  logic [7:0] I, alu_x, alu_y, alu_result, io_in, io_out, resad, resdt;
  logic [2:0] SZCy, alu_flag;
  logic busy, alu_cy, req_d = 1'b0;
  logic [4:0] alu_op;
  int n_chk = 0, n_fail = 0;
  txn_t txq[$];
  txn_t t;
  logic [7:0] dq[$];
  cdec_dp_gen_if #(.DW(8), .AW(8)) mif();
  cdec_dp_gen #(.DW(8), .AW(8), .NGPR(5), .TMO(4)) dut (
    .clock(clock), .reset(reset), .ctrl(ctrl), .I(I), .SZCy(SZCy), .busy(busy),
    .alu_x(alu_x), .alu_y(alu_y), .alu_cy(alu_cy), .alu_op(alu_op),
    .alu_result(alu_result), .alu_flag(alu_flag), .io_in(io_in), .io_out(io_out),
    .resad(resad), .resdt(resdt), .mem(mif)
  );
  always #5 clock = ~clock;
  function automatic logic [16:0] cw(input logic [1:0] mm, input logic f, input logic r,
                                     input logic [3:0] xd, input logic [4:0] op, input logic [3:0] xs);
    return {mm, f, r, xd, op, xs};
  endfunction
  localparam logic [16:0] NOP = {MM_IDLE, 1'b0, 1'b0, 4'hF, 5'h00, XS_PC};
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick(input logic [16:0] c);
    ctrl = c;
    @(negedge clock);
    ctrl = NOP;
  endtask
  task automatic ld(input logic [3:0] xd, input logic [7:0] v);
    io_in = v;
    repeat (2) @(negedge clock);
    tick(cw(MM_IDLE, 1'b0, 1'b0, xd, 5'h00, XS_IPORT));
  endtask
  task automatic dbg(input string tag, input logic [7:0] a, input logic [7:0] e);
    resad = a;
    dq.push_back(e);
    @(negedge clock);
    chk(tag, resdt, dq.pop_front());
  endtask
  always @(negedge clock) begin
    if (mif.mem_req && !req_d) begin
      if (txq.size() == 0) chk("txn_unexpected", 1, 0);
      else begin
        t = txq.pop_front();
        chk("txn_we", mif.mem_we, t.we);
        chk("txn_adrs", mif.mem_adrs, t.adrs);
        chk("txn_wdata", mif.mem_wdata, t.wdata);
      end
    end
    req_d = mif.mem_req;
  end
  initial begin
    #200000;
    $display("FAIL watchdog n_chk=%0d", n_chk);
    $fatal(1, "watchdog");
  end
  initial begin
    ctrl = NOP; alu_result = 8'h00; alu_flag = 3'b000; io_in = 8'h00; resad = 8'h00;
    mif.mem_ack = 1'b0; mif.mem_rdata = 8'h00;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    chk("rst_req", mif.mem_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_io", io_out, 0);
    chk("rst_err", mif.mem_err, 0);
    dbg("rst_pc", DA_PC, 8'h00);
    tick(cw(MM_IDLE, 1'b0, 1'b0, 4'd1, 5'h00, XS_ONES));
    tick(cw(MM_IDLE, 1'b0, 1'b0, XD_IO, 5'h00, 4'd1));
    chk("io_out", io_out, 8'hFF);
    dbg("gpr0", 8'h08, 8'hFF);
    tick(cw(MM_IDLE, 1'b0, 1'b0, XD_I, 5'h00, XS_ONES));
    chk("ireg", I, 8'hFF);
    alu_result = 8'h3C; alu_flag = 3'b101;
    ctrl = cw(MM_IDLE, 1'b1, 1'b1, XD_T, 5'h15, 4'hF);
    #1;
    chk("alu_op", alu_op, 5'h15);
    chk("x_unmapped", alu_x, 8'hFF);
    @(negedge clock);
    ctrl = NOP;
    chk("alu_y", alu_y, 8'hFF);
    chk("szcy", SZCy, 3'b101);
    chk("alu_cy", alu_cy, 1);
    dbg("r", DA_R, 8'h3C);
    dbg("flg", DA_FLG, 8'h0A);
    io_in = 8'hA5;
    ctrl = cw(MM_IDLE, 1'b0, 1'b0, 4'hF, 5'h00, XS_IPORT);
    @(negedge clock);
    chk("iport_lag1", alu_x, 8'h00);
    @(negedge clock);
    chk("iport_lag2", alu_x, 8'hA5);
    ctrl = NOP;
    dbg("iport", DA_IPORT, 8'hA5);
    ld(XD_MAR, 8'h20);
    txq.push_back(txn_t'{1'b0, 8'h20, 8'h00});
    tick(cw(MM_RD, 1'b0, 1'b0, 4'hF, 5'h00, XS_PC));
    for (int i = 1; i <= 4; i++) begin
      chk("rd_req", mif.mem_req, 1);
      chk("rd_busy", busy, 1);
      if (i == 4) begin mif.mem_ack = 1'b1; mif.mem_rdata = 8'h5A; end
      @(negedge clock);
    end
    mif.mem_ack = 1'b0;
    chk("rd_end_req", mif.mem_req, 0);
    chk("rd_end_busy", busy, 0);
    dbg("rd_rdr", DA_RDR, 8'h5A);
    ld(XD_WDR, 8'h33);
    io_in = 8'h99;
    repeat (2) @(negedge clock);
    txq.push_back(txn_t'{1'b1, 8'h20, 8'h33});
    tick(cw(MM_WR, 1'b0, 1'b0, 4'hF, 5'h00, XS_PC));
    chk("wr_we", mif.mem_we, 1);
    tick(cw(MM_RD, 1'b0, 1'b0, XD_MAR, 5'h00, XS_IPORT));
    mif.mem_ack = 1'b1; mif.mem_rdata = 8'h77;
    chk("wr_adrs_hold", mif.mem_adrs, 8'h20);
    chk("wr_wdata", mif.mem_wdata, 8'h33);
    tick(cw(MM_RD, 1'b0, 1'b0, 4'hF, 5'h00, XS_PC));
    mif.mem_ack = 1'b0;
    chk("wr_end_busy", busy, 0);
    chk("wr_end_we", mif.mem_we, 0);
    dbg("wr_mar", DA_MAR, 8'h99);
    dbg("wr_rdr", DA_RDR, 8'h5A);
    txq.push_back(txn_t'{1'b0, 8'h99, 8'h33});
    tick(cw(MM_RD, 1'b0, 1'b0, 4'hF, 5'h00, XS_PC));
    for (int i = 1; i <= 4; i++) begin
      chk("to_busy", busy, 1);
      chk("to_err_early", mif.mem_err, 0);
      @(negedge clock);
    end
    chk("to_idle", busy, 0);
    chk("to_err", mif.mem_err, 1);
    mif.mem_ack = 1'b1; mif.mem_rdata = 8'hEE;
    @(negedge clock);
    mif.mem_ack = 1'b0;
    chk("to_ack_ignored", busy, 0);
    dbg("to_rdr", DA_RDR, 8'h5A);
    dbg("to_status", DA_BUS, 8'h08);
    txq.push_back(txn_t'{1'b1, 8'h99, 8'h33});
    tick(cw(MM_WR, 1'b0, 1'b0, 4'hF, 5'h00, XS_PC));
    chk("rs_busy_before", busy, 1);
    reset = 1'b1;
    @(negedge clock);
    chk("rs_req", mif.mem_req, 0);
    chk("rs_we", mif.mem_we, 0);
    chk("rs_err", mif.mem_err, 0);
    chk("rs_busy", busy, 0);
    chk("rs_io", io_out, 0);
    reset = 1'b0;
    dbg("rs_state", DA_ST, 8'h00);
    ld(4'd9, 8'h13);
    ld(4'd10, 8'h14);
    dbg("gpr3", 8'h13, 8'h13);
    dbg("gpr4", 8'h14, 8'h14);
    dbg("gpr5_none", 8'h15, 8'hFF);
    dbg("gpr0_alias", 8'h10, 8'h00);
    dbg("unmapped", 8'h20, 8'hFF);
    ctrl = cw(MM_IDLE, 1'b0, 1'b0, 4'hF, 5'h00, 4'd10);
    #1;
    chk("x_gpr4", alu_x, 8'h14);
    ctrl = cw(MM_IDLE, 1'b0, 1'b0, 4'hF, 5'h00, 4'd11);
    #1;
    chk("x_gpr_beyond", alu_x, 8'hFF);
    ctrl = NOP;
    @(negedge clock);
    chk("txq_empty", txq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
